// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter
//  Description : Common-data-bus arbiter. Each functional unit owns a
//                one-entry holding slot; a round-robin grant picks at most one
//                pending slot per cycle and drives it onto the registered
//                broadcast port.
//  Revision    : 1.0  initial release
// ============================================================================
module cdb_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_FU     = 4,
    parameter int RS_WIDTH   = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush_i,
    input  logic [NUM_FU-1:0]              fu_valid_i,
    input  logic [NUM_FU*DATA_WIDTH-1:0]   fu_value_i,
    input  logic [NUM_FU*RS_WIDTH-1:0]     fu_rs_i,
    output logic [NUM_FU-1:0]              fu_ready_o,
    output logic                           bcast_valid_o,
    output logic [DATA_WIDTH-1:0]          bcast_value_o,
    output logic [RS_WIDTH-1:0]            bcast_rs_o
);

    localparam int c_PTR_W = $clog2(NUM_FU);
    localparam int c_IDX_W = c_PTR_W + 1;

    logic [NUM_FU-1:0]      r_pending;
    logic [DATA_WIDTH-1:0]  r_held_value [NUM_FU];
    logic [RS_WIDTH-1:0]    r_held_rs    [NUM_FU];
    logic [c_PTR_W-1:0]     r_rr_ptr;
    logic                   r_bcast_valid;
    logic [DATA_WIDTH-1:0]  r_bcast_value;
    logic [RS_WIDTH-1:0]    r_bcast_rs;

    logic                   w_grant_valid;
    logic [c_PTR_W-1:0]     w_grant_idx;
    logic [NUM_FU-1:0]      w_grant_oh;
    logic [c_IDX_W-1:0]     w_scan_idx;
    logic [NUM_FU-1:0]      w_ready;
    logic [NUM_FU-1:0]      w_accept;
    logic [c_PTR_W-1:0]     w_rr_next;

    // Round-robin search: first pending slot at or above rr_ptr, wrapping.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        w_grant_oh    = '0;
        w_scan_idx    = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            w_scan_idx = {1'b0, r_rr_ptr} + c_IDX_W'(k);
            if (w_scan_idx >= c_IDX_W'(NUM_FU)) begin
                w_scan_idx = w_scan_idx - c_IDX_W'(NUM_FU);
            end
            if (!w_grant_valid && r_pending[w_scan_idx[c_PTR_W-1:0]]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = w_scan_idx[c_PTR_W-1:0];
            end
        end
        if (w_grant_valid) begin
            w_grant_oh[w_grant_idx] = 1'b1;
        end
    end

    // Pointer advances to the slot just after the winner, wrapping at NUM_FU.
    always_comb begin
        w_rr_next = r_rr_ptr;
        if (w_grant_idx == c_PTR_W'(NUM_FU - 1)) begin
            w_rr_next = '0;
        end else begin
            w_rr_next = w_grant_idx + c_PTR_W'(1);
        end
    end

    generate
        for (genvar i = 0; i < NUM_FU; i++) begin : g_slot
            // A slot being granted this cycle can be refilled on the same edge.
            assign w_ready[i]  = !rst && !flush_i && (!r_pending[i] || w_grant_oh[i]);
            assign w_accept[i] = fu_valid_i[i] && w_ready[i];

            // Holding-slot payload; only meaningful while pending, so no reset.
            always_ff @(posedge clk) begin
                if (w_accept[i]) begin
                    r_held_value[i] <= fu_value_i[i*DATA_WIDTH +: DATA_WIDTH];
                    r_held_rs[i]    <= fu_rs_i[i*RS_WIDTH +: RS_WIDTH];
                end
            end
        end
    endgenerate

    // Pending flags: accept sets, grant clears (accept wins on the same slot).
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            r_pending <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (w_accept[i]) begin
                    r_pending[i] <= 1'b1;
                end else if (w_grant_oh[i]) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

    // Registered broadcast port and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr      <= '0;
            r_bcast_valid <= 1'b0;
            r_bcast_value <= '0;
            r_bcast_rs    <= '0;
        end else if (flush_i) begin
            r_bcast_valid <= 1'b0;
        end else if (w_grant_valid) begin
            r_bcast_valid <= 1'b1;
            r_bcast_value <= r_held_value[w_grant_idx];
            r_bcast_rs    <= r_held_rs[w_grant_idx];
            r_rr_ptr      <= w_rr_next;
        end else begin
            r_bcast_valid <= 1'b0;
        end
    end

    assign fu_ready_o    = w_ready;
    assign bcast_valid_o = r_bcast_valid;
    assign bcast_value_o = r_bcast_value;
    assign bcast_rs_o    = r_bcast_rs;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdb_arbiter
//  Description : Directed bench for cdb_arbiter with a broadcast scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cdb_arbiter;

    localparam int c_DW  = 64;
    localparam int c_NFU = 4;
    localparam int c_RSW = 2;

    logic                    clk;
    logic                    rst;
    logic                    flush_i;
    logic [c_NFU-1:0]        fu_valid_i;
    logic [c_NFU*c_DW-1:0]   fu_value_i;
    logic [c_NFU*c_RSW-1:0]  fu_rs_i;
    logic [c_NFU-1:0]        fu_ready_o;
    logic                    bcast_valid_o;
    logic [c_DW-1:0]         bcast_value_o;
    logic [c_RSW-1:0]        bcast_rs_o;

    typedef struct {
        logic [c_DW-1:0]  value;
        logic [c_RSW-1:0] rs;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_pass   = 0;
    int   n_total  = 0;

    cdb_arbiter #(
        .DATA_WIDTH (c_DW),
        .NUM_FU     (c_NFU),
        .RS_WIDTH   (c_RSW)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .fu_valid_i    (fu_valid_i),
        .fu_value_i    (fu_value_i),
        .fu_rs_i       (fu_rs_i),
        .fu_ready_o    (fu_ready_o),
        .bcast_valid_o (bcast_valid_o),
        .bcast_value_o (bcast_value_o),
        .bcast_rs_o    (bcast_rs_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle n is the interval following the n-th rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        assert (act === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic drive(input int i, input logic [c_DW-1:0] v, input logic [c_RSW-1:0] r);
        fu_valid_i[i]               = 1'b1;
        fu_value_i[i*c_DW +: c_DW]  = v;
        fu_rs_i[i*c_RSW +: c_RSW]   = r;
    endtask

    task automatic push(input logic [c_DW-1:0] v, input logic [c_RSW-1:0] r, input int c);
        sb.push_back('{value: v, rs: r, cyc: c});
    endtask

    // Scoreboard: every broadcast must match the oldest expected entry in the
    // exact cycle it was predicted for.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            chk("bcast_missing_cycle", 64'(cyc), 64'(sb[0].cyc));
            void'(sb.pop_front());
        end
        if (bcast_valid_o === 1'b1) begin
            if (sb.size() == 0 || sb[0].cyc != cyc) begin
                chk("bcast_unexpected", 64'(bcast_valid_o), 64'd0);
            end else begin
                chk("bcast_value", bcast_value_o, sb[0].value);
                chk("bcast_rs", 64'(bcast_rs_o), 64'(sb[0].rs));
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        rst        = 1'b1;
        flush_i    = 1'b0;
        fu_valid_i = '0;
        fu_value_i = '0;
        fu_rs_i    = '0;
        idle(2);
        chk("rst_ready", 64'(fu_ready_o), 64'h0);
        chk("rst_bvalid", 64'(bcast_valid_o), 64'h0);
        chk("rst_bvalue", bcast_value_o, 64'h0);
        chk("rst_brs", 64'(bcast_rs_o), 64'h0);
        rst = 1'b0;
        step();

        // Full contention from rr_ptr=0: broadcasts 10..13 in cycles +2..+5.
        for (int i = 0; i < c_NFU; i++) begin
            drive(i, 64'(10 + i), c_RSW'(i));
            push(64'(10 + i), c_RSW'(i), cyc + 2 + i);
        end
        #1 chk("cont_ready_c0", 64'(fu_ready_o), 64'hF);
        step();
        fu_valid_i = '0;
        #1 chk("cont_ready_c1", 64'(fu_ready_o), 64'b0001);
        step();
        chk("cont_ready_c2", 64'(fu_ready_o), 64'b0011);
        step();
        chk("cont_ready_c3", 64'(fu_ready_o), 64'b0111);
        step();
        chk("cont_ready_c4", 64'(fu_ready_o), 64'b1111);
        idle(3);

        // Single uncontended result on FU2: broadcast exactly two cycles later.
        drive(2, 64'hDEAD, 2'd2);
        push(64'hDEAD, 2'd2, cyc + 2);
        #1 chk("single_ready", 64'(fu_ready_o), 64'hF);
        step();
        fu_valid_i = '0;
        idle(3);

        // Rotation from rr_ptr=3 with slots 0 and 3: slot 3 first, then 0.
        drive(0, 64'h30, 2'd0);
        drive(3, 64'h33, 2'd3);
        push(64'h33, 2'd3, cyc + 2);
        push(64'h30, 2'd0, cyc + 3);
        step();
        fu_valid_i = '0;
        #1 chk("rot_ready", 64'(fu_ready_o), 64'b1110);
        idle(4);

        // Back-to-back stream on FU0: ready never drops.
        for (int v = 1; v <= 4; v++) begin
            drive(0, 64'(v), 2'd0);
            push(64'(v), 2'd0, cyc + 2);
            #1 chk("b2b_ready", 64'(fu_ready_o), 64'hF);
            step();
        end
        fu_valid_i = '0;
        idle(4);

        // Flush with slots 1 and 2 pending: neither is ever broadcast.
        drive(1, 64'h41, 2'd1);
        drive(2, 64'h42, 2'd2);
        step();
        fu_valid_i = '0;
        flush_i    = 1'b1;
        #1 chk("flush_ready", 64'(fu_ready_o), 64'h0);
        step();
        flush_i = 1'b0;
        #1 chk("flush_bvalid_c1", 64'(bcast_valid_o), 64'h0);
        chk("flush_ready_after", 64'(fu_ready_o), 64'hF);
        step();
        chk("flush_bvalid_c2", 64'(bcast_valid_o), 64'h0);
        idle(3);

        // Reset mid-operation: rr_ptr=1, so slot 1 broadcasts, 0/2/3 discarded.
        for (int i = 0; i < c_NFU; i++) drive(i, 64'(8'h50 + i), c_RSW'(i));
        step();
        fu_valid_i = '0;
        step();
        push(64'h51, 2'd1, cyc);
        rst = 1'b1;
        #1 chk("midrst_ready", 64'(fu_ready_o), 64'h0);
        chk("midrst_bvalid_before", 64'(bcast_valid_o), 64'h1);
        step();
        chk("midrst_bvalid", 64'(bcast_valid_o), 64'h0);
        chk("midrst_bvalue", bcast_value_o, 64'h0);
        chk("midrst_brs", 64'(bcast_rs_o), 64'h0);
        rst = 1'b0;
        idle(6);

        chk("sb_empty", 64'(sb.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
